// File: rtl/noise_access_sched.sv
// Shares one 24-bit LFSR noise generator among NUM_REQ requesters: reset pulse, warm-up, round-robin bursts.
// Latency: a request seen in ARB gives grant/out_valid next cycle; 1-cycle ARB bubble between bursts.
// Backpressure: out_ready low holds data/id/grant and stalls the generator; optional NOISE_STATS_EN adds counters.
module noise_access_sched #(
   parameter int NUM_REQ       = 4,
   parameter int ID_W          = 2,
   parameter int WIDTH         = 24,
   parameter int BURST_LEN     = 4,
   parameter int WARMUP_CYCLES = 24
) (
   input  logic               clk,
   input  logic               reset,
   output logic               gen_enable,
   output logic               gen_reset,
   input  logic [WIDTH-1:0]   gen_q,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   output logic [ID_W-1:0]    out_id,
   input  logic               out_ready,
   input  logic               cfg_we,
   input  logic [ID_W-1:0]    cfg_addr,
   input  logic [2:0]         cfg_shift
`ifdef NOISE_STATS_EN
   ,
   output logic [15:0]        sample_count,
   output logic [7:0]         abort_count
`endif
);

   typedef enum logic [1:0] {
      GRST  = 2'd0,
      WARM  = 2'd1,
      ARB   = 2'd2,
      SERVE = 2'd3
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [7:0]           warm_cnt;
   logic [7:0]           warm_cnt_nxt;
   logic [7:0]           burst_cnt;
   logic [7:0]           burst_cnt_nxt;
   logic [ID_W-1:0]      rr_ptr;
   logic [ID_W-1:0]      rr_ptr_nxt;
   logic [ID_W-1:0]      out_id_nxt;
   logic [NUM_REQ-1:0]   grant_nxt;
   logic [2:0]           shift_tbl [NUM_REQ];

   logic                 pick_vld;
   logic [ID_W-1:0]      pick_id;
   logic [ID_W-1:0]      pick_sel;
   int                   pick_idx;

   logic                 req_act;
   logic                 xfer;
   logic [ID_W-1:0]      id_inc;
   logic signed [WIDTH-1:0] shifted;

   // Active requester still asking, and a transfer when the consumer takes the sample.
   assign req_act   = req[out_id];
   assign out_valid = (state == SERVE) && req_act && !reset;
   assign xfer      = out_valid && out_ready;

   // Next round-robin start point: one past the requester just served.
   assign id_inc = (out_id == ID_W'(NUM_REQ - 1)) ? '0 : out_id + 1'b1;

   // Round-robin pick: first requester at or after rr_ptr, wrapping.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      pick_idx = 0;
      pick_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pick_idx = (int'(rr_ptr) + i) % NUM_REQ;
         pick_sel = ID_W'(pick_idx);
         if (!pick_vld && req[pick_sel]) begin
            pick_vld = 1'b1;
            pick_id  = pick_sel;
         end
      end
   end

   // Next-state and generator control; generator outputs are quiet while reset is held.
   always_comb begin
      state_nxt     = state;
      warm_cnt_nxt  = warm_cnt;
      burst_cnt_nxt = burst_cnt;
      rr_ptr_nxt    = rr_ptr;
      grant_nxt     = grant;
      out_id_nxt    = out_id;
      gen_reset     = 1'b0;
      gen_enable    = 1'b0;
      case (state)
         GRST: begin
            gen_reset    = 1'b1;
            warm_cnt_nxt = '0;
            state_nxt    = WARM;
         end
         WARM: begin
            gen_enable = 1'b1;
            if (warm_cnt == 8'(WARMUP_CYCLES - 1)) begin
               state_nxt = ARB;
            end else begin
               warm_cnt_nxt = warm_cnt + 8'd1;
            end
         end
         ARB: begin
            if (pick_vld) begin
               grant_nxt          = '0;
               grant_nxt[pick_id] = 1'b1;
               out_id_nxt         = pick_id;
               burst_cnt_nxt      = 8'(BURST_LEN);
               state_nxt          = SERVE;
            end
         end
         SERVE: begin
            if (!req_act) begin
               // Requester dropped out mid-burst: abandon it and move on.
               rr_ptr_nxt = id_inc;
               grant_nxt  = '0;
               state_nxt  = ARB;
            end else if (xfer) begin
               gen_enable    = 1'b1;
               burst_cnt_nxt = burst_cnt - 8'd1;
               if (burst_cnt == 8'd1) begin
                  rr_ptr_nxt = id_inc;
                  grant_nxt  = '0;
                  state_nxt  = ARB;
               end
            end
         end
         default: state_nxt = GRST;
      endcase
      if (reset) begin
         gen_reset  = 1'b0;
         gen_enable = 1'b0;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= GRST;
      end else begin
         state <= state_nxt;
      end
   end

   // Burst context: counters, round-robin pointer, registered grant and id.
   always_ff @(posedge clk) begin
      if (reset) begin
         warm_cnt  <= '0;
         burst_cnt <= '0;
         rr_ptr    <= '0;
         grant     <= '0;
         out_id    <= '0;
      end else begin
         warm_cnt  <= warm_cnt_nxt;
         burst_cnt <= burst_cnt_nxt;
         rr_ptr    <= rr_ptr_nxt;
         grant     <= grant_nxt;
         out_id    <= out_id_nxt;
      end
   end

   // Per-requester attenuation table; writes land in any state except reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            shift_tbl[i] <= '0;
         end
      end else if (cfg_we) begin
         shift_tbl[cfg_addr] <= cfg_shift;
      end
   end

   // Attenuated sample, masked to zero when nothing is offered.
   always_comb begin
      shifted  = $signed(gen_q) >>> shift_tbl[out_id];
      out_data = out_valid ? shifted : '0;
   end

`ifdef NOISE_STATS_EN
   // Transfer counter wraps; abort counter saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         sample_count <= '0;
         abort_count  <= '0;
      end else begin
         if (xfer) begin
            sample_count <= sample_count + 16'd1;
         end
         if ((state == SERVE) && !req_act && (abort_count != 8'hFF)) begin
            abort_count <= abort_count + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_noise_access_sched.sv
// Directed bench for noise_access_sched: warm-up sequence, round-robin bursts, attenuation, stall, abort, mid-burst reset.
// Inputs driven 2 time units after the rising edge, outputs sampled 1 unit later.
// Optional NOISE_STATS_EN counters checked when the macro is defined.
module tb_noise_access_sched;
   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int WIDTH   = 24;

   logic               clk = 1'b0;
   logic               reset;
   logic               gen_enable;
   logic               gen_reset;
   logic [WIDTH-1:0]   gen_q;
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic [WIDTH-1:0]   out_data;
   logic               out_valid;
   logic [ID_W-1:0]    out_id;
   logic               out_ready;
   logic               cfg_we;
   logic [ID_W-1:0]    cfg_addr;
   logic [2:0]         cfg_shift;
`ifdef NOISE_STATS_EN
   logic [15:0]        sample_count;
   logic [7:0]         abort_count;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   noise_access_sched dut (
      .clk        (clk),
      .reset      (reset),
      .gen_enable (gen_enable),
      .gen_reset  (gen_reset),
      .gen_q      (gen_q),
      .req        (req),
      .grant      (grant),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_id     (out_id),
      .out_ready  (out_ready),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_shift  (cfg_shift)
`ifdef NOISE_STATS_EN
      ,
      .sample_count (sample_count),
      .abort_count  (abort_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_valid"}, 32'(out_valid), 32'h0);
      chk({tag, "_en"}, 32'(gen_enable), 32'h0);
      chk({tag, "_data"}, 32'(out_data), 32'h0);
   endtask

   task automatic chk_serve(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic [23:0] d, input logic en);
      chk({tag, "_grant"}, 32'(grant), 32'(g));
      chk({tag, "_valid"}, 32'(out_valid), 32'h1);
      chk({tag, "_id"}, 32'(out_id), 32'(id));
      chk({tag, "_data"}, 32'(out_data), 32'(d));
      chk({tag, "_en"}, 32'(gen_enable), 32'(en));
   endtask

   initial begin
      int en_cnt;
      int rst_cnt;
      int vld_cnt;
      int last_en;
      logic [3:0]  one_hot;
      logic [3:0]  exp_g;
      logic [1:0]  exp_id;
      logic [23:0] exp_d;

      one_hot   = 4'b0001;
      reset     = 1'b1;
      req       = '0;
      out_ready = 1'b0;
      gen_q     = 24'h123456;
      // Config write while reset is held must be ignored.
      cfg_we    = 1'b1;
      cfg_addr  = 2'd0;
      cfg_shift = 3'd5;

      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk_idle("rst");
         chk("rst_genrst", 32'(gen_reset), 32'h0);
         chk("rst_id", 32'(out_id), 32'h0);
      end

      // Release: cycle 1 is the generator reset pulse.
      cfg_we = 1'b0;
      reset  = 1'b0;
      settle();
      chk("c1_genrst", 32'(gen_reset), 32'h1);
      chk("c1_en", 32'(gen_enable), 32'h0);
      en_cnt  = 0;
      rst_cnt = 1;
      vld_cnt = 0;
      last_en = 0;
      for (int c = 2; c <= 30; c++) begin
         tick();
         settle();
         if (gen_enable) begin
            en_cnt++;
            last_en = c;
         end
         if (gen_reset) rst_cnt++;
         if (out_valid) vld_cnt++;
      end
      chk("warm_en_cnt", 32'(en_cnt), 32'd24);
      chk("warm_last_en", 32'(last_en), 32'd25);
      chk("warm_rst_cnt", 32'(rst_cnt), 32'd1);
      chk("warm_vld_cnt", 32'(vld_cnt), 32'd0);

      // Attenuation of 3 on requester 2 while idle in ARB.
      cfg_we    = 1'b1;
      cfg_addr  = 2'd2;
      cfg_shift = 3'd3;
      tick();
      cfg_we = 1'b0;
      settle();
      chk_idle("arb_idle");

      // All requesting: five round-robin bursts of four.
      gen_q     = 24'h800000;
      req       = 4'b1111;
      out_ready = 1'b1;
      for (int b = 0; b < 5; b++) begin
         exp_id = 2'(b % 4);
         exp_g  = one_hot << exp_id;
         exp_d  = (exp_id == 2'd2) ? 24'hF00000 : 24'h800000;
         for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            chk_serve("rr", exp_g, exp_id, exp_d, 1'b1);
         end
         tick();
         settle();
         chk_idle("rr_gap");
      end

      // Requester 1 burst with a 5-cycle stall after the first transfer.
      tick();
      settle();
      chk_serve("st_c1", 4'b0010, 2'd1, 24'h800000, 1'b1);
      tick();
      out_ready = 1'b0;
      settle();
      chk_serve("stall", 4'b0010, 2'd1, 24'h800000, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         settle();
         chk_serve("stall", 4'b0010, 2'd1, 24'h800000, 1'b0);
      end
      tick();
      out_ready = 1'b1;
      settle();
      chk_serve("st_resume", 4'b0010, 2'd1, 24'h800000, 1'b1);
      for (int k = 0; k < 2; k++) begin
         tick();
         settle();
         chk_serve("st_tail", 4'b0010, 2'd1, 24'h800000, 1'b1);
      end
      tick();
      settle();
      chk_idle("st_gap");

      // Requester 1 drops after two transfers.
      req = 4'b0010;
      tick();
      settle();
      chk_serve("ab_c1", 4'b0010, 2'd1, 24'h800000, 1'b1);
      tick();
      settle();
      chk_serve("ab_c2", 4'b0010, 2'd1, 24'h800000, 1'b1);
      tick();
      req = 4'b0101;
      settle();
      chk("ab_valid", 32'(out_valid), 32'h0);
      chk("ab_en", 32'(gen_enable), 32'h0);
      chk("ab_grant_held", 32'(grant), 32'h2);
      tick();
      settle();
      chk_idle("ab_arb");
`ifdef NOISE_STATS_EN
      chk("ab_abort_count", 32'(abort_count), 32'd1);
      chk("ab_sample_count", 32'(sample_count), 32'd26);
`endif
      tick();
      settle();
      chk_serve("ab_next", 4'b0100, 2'd2, 24'hF00000, 1'b1);

      // Reset mid-burst.
      tick();
      reset = 1'b1;
      tick();
      settle();
      chk_idle("mid_rst");
      chk("mid_rst_id", 32'(out_id), 32'h0);
`ifdef NOISE_STATS_EN
      chk("mid_rst_abort", 32'(abort_count), 32'd0);
      chk("mid_rst_samples", 32'(sample_count), 32'd0);
`endif
      reset = 1'b0;
      settle();
      chk("re_genrst", 32'(gen_reset), 32'h1);
      for (int c = 0; c < 24; c++) begin
         tick();
         settle();
         chk("re_warm_en", 32'(gen_enable), 32'h1);
         chk("re_warm_valid", 32'(out_valid), 32'h0);
      end
      tick();
      settle();
      chk_idle("re_arb");
      chk("re_arb_genrst", 32'(gen_reset), 32'h0);
      tick();
      settle();
      chk_serve("re_rr0", 4'b0001, 2'd0, 24'h800000, 1'b1);
      for (int k = 0; k < 3; k++) tick();
      tick();
      tick();
      settle();
      // Shift table was cleared by reset: requester 2 is no longer attenuated.
      chk_serve("re_cfg_clr", 4'b0100, 2'd2, 24'h800000, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
